// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
// Module      : debounce
// Description : Turns a raw, asynchronous, bouncing pushbutton/switch input
//               into a clean level that is synchronous to clk. The input
//               first passes through a SYNC_STAGES-deep flop synchronizer.
//               A four-state FSM with a down-counter then accepts a new
//               level only after the synchronized input has been stable for
//               DEBOUNCE_CYCLES clocks.
//
//               The level output is intended to feed the level input of the
//               downstream edge detector.
//
// Parameters  : DEBOUNCE_CYCLES - clocks of stability required before
//                                 level changes (must be >= 1)
//               SYNC_STAGES     - synchronizer depth (must be >= 2)
//
// Ports       : clk      in  1  rising-edge system clock
//               reset    in  1  synchronous, active-high reset
//               raw_in   in  1  asynchronous, bouncing input
//               level    out 1  debounced, synchronized level (registered)
//               settling out 1  high while a candidate change is being
//                               timed (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int DEBOUNCE_CYCLES = 330000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic settling
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only ever holds 0..DEBOUNCE_CYCLES-1. It needs at least one
    // bit, even when DEBOUNCE_CYCLES is 1.
    localparam int c_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [c_CW-1:0] c_RELOAD   = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    // State encoding. Bit 1 carries the current accepted level.
    localparam logic [1:0] c_ST_ZERO  = 2'b00;
    localparam logic [1:0] c_ST_WAIT1 = 2'b01;
    localparam logic [1:0] c_ST_ONE   = 2'b10;
    localparam logic [1:0] c_ST_WAIT0 = 2'b11;

    // ------------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------------
    // raw_in is touched only by the first synchronizer stage. Every other
    // piece of logic looks only at the last stage.
    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   w_sync;

    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], raw_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign w_sync = r_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Debounce FSM: state and counter registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state_q;
    logic [1:0]      w_state_d;
    logic [c_CW-1:0] r_cnt_q;
    logic [c_CW-1:0] w_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_ST_ZERO;
            r_cnt_q   <= c_CNT_ZERO;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce FSM: next-state and counter logic
    // ------------------------------------------------------------------------
    // In the WAIT states, a reversal of the synchronized input is checked
    // before counter expiry. A reversal in the same cycle as expiry therefore
    // still rejects the change. The counter keeps its value whenever it is
    // not in use, and the next qualifying change reloads it.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;

        case (r_state_q)
            c_ST_ZERO: begin
                if (w_sync) begin
                    w_state_d = c_ST_WAIT1;
                    w_cnt_d   = c_RELOAD;
                end
            end

            c_ST_WAIT1: begin
                if (!w_sync) begin
                    w_state_d = c_ST_ZERO;
                end else if (r_cnt_q == c_CNT_ZERO) begin
                    w_state_d = c_ST_ONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
            end

            c_ST_ONE: begin
                if (!w_sync) begin
                    w_state_d = c_ST_WAIT0;
                    w_cnt_d   = c_RELOAD;
                end
            end

            c_ST_WAIT0: begin
                if (w_sync) begin
                    w_state_d = c_ST_ONE;
                end else if (r_cnt_q == c_CNT_ZERO) begin
                    w_state_d = c_ST_ZERO;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
            end

            default: begin
                w_state_d = c_ST_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Debounce FSM: output decode
    // ------------------------------------------------------------------------
    // The outputs are decoded from the next state and then registered, so
    // they change on the same edge as the state register and never glitch.
    logic w_level_d;
    logic w_settling_d;
    logic r_level_q;
    logic r_settling_q;

    always_comb begin
        w_level_d    = 1'b0;
        w_settling_d = 1'b0;
        case (w_state_d)
            c_ST_ZERO: begin
                w_level_d    = 1'b0;
                w_settling_d = 1'b0;
            end
            c_ST_WAIT1: begin
                w_level_d    = 1'b0;
                w_settling_d = 1'b1;
            end
            c_ST_ONE: begin
                w_level_d    = 1'b1;
                w_settling_d = 1'b0;
            end
            c_ST_WAIT0: begin
                w_level_d    = 1'b1;
                w_settling_d = 1'b1;
            end
            default: begin
                w_level_d    = 1'b0;
                w_settling_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_q    <= 1'b0;
            r_settling_q <= 1'b0;
        end else begin
            r_level_q    <= w_level_d;
            r_settling_q <= w_settling_d;
        end
    end

    assign level    = r_level_q;
    assign settling = r_settling_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce
// Description : Self-checking bench for debounce (DEBOUNCE_CYCLES=8,
//               SYNC_STAGES=2). Each stimulus step pushes the cycle at which
//               it expects level and settling to change. A negedge monitor
//               pops those events and compares both outputs on every cycle.
//               A small rising-edge detector models the downstream tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce;

    localparam int c_DEB  = 8;
    localparam int c_SYNC = 2;
    localparam int c_RISE = c_SYNC + 1;           // settling rises
    localparam int c_LAT  = c_SYNC + 1 + c_DEB;   // level toggles (11)

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic level;
    logic settling;

    always #5 clk = ~clk;

    debounce #(
        .DEBOUNCE_CYCLES(c_DEB),
        .SYNC_STAGES    (c_SYNC)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_in),
        .level   (level),
        .settling(settling)
    );

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    ev_t  q_level[$];
    ev_t  q_settle[$];
    int   cyc        = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    logic exp_level  = 1'b0;
    logic exp_settle = 1'b0;
    bit   chk_en     = 1'b0;
    bit   tick_en    = 1'b0;
    int   n_ticks    = 0;
    int   tick_cyc   = -1;

    // Downstream edge detector: a one-clock tick, one clock after level rises.
    logic r_lvl_d = 1'b0;
    logic r_tick  = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        r_lvl_d <= level;
        r_tick  <= level & ~r_lvl_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_lvl(input int c, input logic v);
        q_level.push_back('{cyc: c, val: v});
    endtask

    task automatic exp_set(input int c, input logic v);
        q_settle.push_back('{cyc: c, val: v});
    endtask

    // Advance n rising edges, then move 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a clean, held change to value v.
    task automatic press(input logic v, input int hold);
        int t;
        t      = cyc;
        raw_in = v;
        exp_set(t + c_RISE, 1'b1);
        exp_set(t + c_LAT, 1'b0);
        exp_lvl(t + c_LAT, v);
        step(hold);
    endtask

    // Drive a pulse of len clocks (len <= DEBOUNCE_CYCLES) that must be
    // rejected. settling is high for exactly len cycles.
    task automatic glitch(input logic v, input int len);
        int t;
        t      = cyc;
        raw_in = v;
        exp_set(t + c_RISE, 1'b1);
        exp_set(t + c_RISE + len, 1'b0);
        step(len);
        raw_in = ~v;
        step(16);
    endtask

    // Monitor: apply the scheduled events, then compare the outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            while (q_level.size() > 0 && q_level[0].cyc <= cyc) begin
                exp_level = q_level[0].val;
                void'(q_level.pop_front());
            end
            while (q_settle.size() > 0 && q_settle[0].cyc <= cyc) begin
                exp_settle = q_settle[0].val;
                void'(q_settle.pop_front());
            end
            check("level", level, exp_level);
            check("settling", settling, exp_settle);
            if (tick_en && r_tick === 1'b1) begin
                n_ticks++;
                tick_cyc = cyc;
            end
        end
    end

    initial begin
        int t0;
        int r;

        // 1. Reset, then idle low.
        reset  = 1'b1;
        raw_in = 1'b0;
        step(3);
        chk_en = 1'b1;
        reset  = 1'b0;
        step(20);

        // 2. Clean rise.
        press(1'b1, 20);

        // 3. Short low pulses from ONE. The 8-clock pulse reverses in the same
        //    cycle as counter expiry, so it is still rejected.
        glitch(1'b0, 5);
        glitch(1'b0, 7);
        glitch(1'b0, 8);
        press(1'b0, 20);
        glitch(1'b1, 3);

        // 4. Bounce train 1,0,1,1,0,1, then held high.
        t0 = cyc;
        exp_set(t0 + 3, 1'b1);
        exp_set(t0 + 4, 1'b0);
        exp_set(t0 + 5, 1'b1);
        exp_set(t0 + 7, 1'b0);
        raw_in = 1'b1; step(1);
        raw_in = 1'b0; step(1);
        raw_in = 1'b1; step(1);
        raw_in = 1'b1; step(1);
        raw_in = 1'b0; step(1);
        press(1'b1, 20);
        press(1'b0, 20);

        // 5. Reset while in WAIT1 with cnt=4, raw_in held high throughout.
        t0     = cyc;
        raw_in = 1'b1;
        exp_set(t0 + c_RISE, 1'b1);
        exp_set(t0 + 7, 1'b0);
        step(6);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        r     = cyc;
        exp_set(r + c_RISE, 1'b1);
        exp_set(r + c_LAT, 1'b0);
        exp_lvl(r + c_LAT, 1'b1);
        step(20);
        press(1'b0, 20);

        // 6. One clean press feeding the edge detector.
        n_ticks = 0;
        tick_en = 1'b1;
        t0      = cyc;
        press(1'b1, 50);
        press(1'b0, 25);
        tick_en = 1'b0;
        check("tick_count", n_ticks, 1);
        check("tick_cycle", tick_cyc, t0 + c_LAT + 1);

        step(2);
        chk_en = 1'b0;
        check("level_events_left", q_level.size(), 0);
        check("settle_events_left", q_settle.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
